// File: rtl/mem_lsu.sv
// In-order load/store unit: buffers ALU memory requests in a FIFO and issues them on a
// single-outstanding data bus, aligning store data and extending load results.
module mem_lsu #(
  parameter int XLEN     = 32,
  parameter int PARA_LEN = 11,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_vld,
  input  logic [PARA_LEN-1:0] mem_para,
  input  logic [XLEN-1:0]     mem_addr,
  input  logic [XLEN-1:0]     mem_wdata,
  output logic                mem_rdy,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic                dmem_ack,
  input  logic                dmem_resp,
  input  logic [XLEN-1:0]     dmem_rdata,
  input  logic                dmem_err,
  output logic [4:0]          wb_sel,
  output logic [XLEN-1:0]     wb_data,
  output logic                lsu_err,
  output logic                lsu_idle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] sz, input logic [XLEN-1:0] d);
    case (sz)
      2'b00:   return {(XLEN/8){d[7:0]}};
      2'b01:   return {(XLEN/16){d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [XLEN-1:0] rdata);
    logic        [XLEN-1:0] s;
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    s = rdata >> {a, 3'b000};
    b = s[7:0];
    h = s[15:0];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return s;
    endcase
  endfunction

  logic [4:0]      q_rd    [DEPTH];
  logic            q_st    [DEPTH];
  logic [2:0]      q_f3    [DEPTH];
  logic [XLEN-1:0] q_addr  [DEPTH];
  logic [XLEN-1:0] q_wdata [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;

  logic            full, empty, push, pop, resp_fire, bad;
  logic [4:0]      h_rd;
  logic            h_st;
  logic [2:0]      h_f3;
  logic [XLEN-1:0] h_addr, h_wdata;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign mem_rdy  = !full;
  assign lsu_idle = empty && (state == S_IDLE);
  assign push     = mem_vld && mem_rdy && (mem_para[PARA_LEN-1:PARA_LEN-2] == 2'b00);

  assign h_rd    = q_rd[rd_ptr];
  assign h_st    = q_st[rd_ptr];
  assign h_f3    = q_f3[rd_ptr];
  assign h_addr  = q_addr[rd_ptr];
  assign h_wdata = q_wdata[rd_ptr];

  // Illegal funct3 or an address not aligned to the access size; such entries never reach the bus.
  always_comb begin
    bad = 1'b0;
    if (h_st) bad = h_f3[2] || (h_f3[1:0] == 2'b11);
    else      bad = (h_f3 == 3'b011) || (h_f3[2:1] == 2'b11);
    if ((h_f3[1:0] == 2'b01) && h_addr[0])           bad = 1'b1;
    if ((h_f3[1:0] == 2'b10) && (h_addr[1:0] != 2'b00)) bad = 1'b1;
  end

  // A response arriving together with the ack completes the transaction in the REQ state.
  assign resp_fire = ((state == S_REQ) && dmem_ack && dmem_resp) ||
                     ((state == S_RESP) && dmem_resp);
  assign pop       = resp_fire || ((state == S_IDLE) && !empty && bad);

  // Stage p0: request capture into FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]    <= mem_para[8:4];
      q_st[wr_ptr]    <= mem_para[3];
      q_f3[wr_ptr]    <= mem_para[2:0];
      q_addr[wr_ptr]  <= mem_addr;
      q_wdata[wr_ptr] <= mem_wdata;
    end
  end

  // Stage p1: bus issue, response handling and writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_sel     <= '0;
      wb_data    <= '0;
      lsu_err    <= 1'b0;
    end else begin
      wb_sel  <= '0;
      wb_data <= '0;
      lsu_err <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (resp_fire) begin
        if (dmem_err) begin
          lsu_err <= 1'b1;
        end else if (!h_st && (h_rd != 5'd0)) begin
          wb_sel  <= h_rd;
          wb_data <= load_ext(h_f3, h_addr[1:0], dmem_rdata);
        end
      end

      case (state)
        S_IDLE: begin
          if (!empty) begin
            if (bad) begin
              lsu_err <= 1'b1;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= h_st;
              dmem_addr  <= {h_addr[XLEN-1:2], 2'b00};
              dmem_be    <= lane_be(h_f3[1:0], h_addr[1:0]);
              dmem_wdata <= lane_wdata(h_f3[1:0], h_wdata);
              state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state    <= dmem_resp ? S_IDLE : S_RESP;
          end
        end
        S_RESP: begin
          if (dmem_resp) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
